// File: rtl/mc_controller_pkg.sv
// Shared definitions for the multicycle controller: opcode/funct values,
// ALU control encodings, datapath select codes and the FSM state type.
// Optional feature macro: MC_CONTROLLER_JUMP_EN (adds j instruction support).
package mc_controller_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALUC_W  = 3;
    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned STATE_W = 4;

    // Opcodes (instr[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
`ifdef MC_CONTROLLER_JUMP_EN
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
`endif

    // R-type function codes (instr[5:0])
    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

    // ALU operation codes; ALU_NONE is the unused code (ALU result 0)
    localparam logic [ALUC_W-1:0] ALU_AND  = 3'b000;
    localparam logic [ALUC_W-1:0] ALU_OR   = 3'b001;
    localparam logic [ALUC_W-1:0] ALU_ADD  = 3'b010;
    localparam logic [ALUC_W-1:0] ALU_NONE = 3'b011;
    localparam logic [ALUC_W-1:0] ALU_SUB  = 3'b110;
    localparam logic [ALUC_W-1:0] ALU_SLT  = 3'b111;

    // FSM-to-aludec operation request
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [SEL_W-1:0] SRCB_REG   = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMMSH = 2'b11;

    // Next-PC select
    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
`ifdef MC_CONTROLLER_JUMP_EN
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;
`endif

    // State encodings (legacy-compatible constants backing the enum)
    localparam logic [STATE_W-1:0] S_FETCH    = 4'd0;
    localparam logic [STATE_W-1:0] S_DECODE   = 4'd1;
    localparam logic [STATE_W-1:0] S_MEMADR   = 4'd2;
    localparam logic [STATE_W-1:0] S_MEMRD    = 4'd3;
    localparam logic [STATE_W-1:0] S_MEMWB    = 4'd4;
    localparam logic [STATE_W-1:0] S_MEMWR    = 4'd5;
    localparam logic [STATE_W-1:0] S_EXECUTE  = 4'd6;
    localparam logic [STATE_W-1:0] S_ALUWB    = 4'd7;
    localparam logic [STATE_W-1:0] S_BRANCH   = 4'd8;
    localparam logic [STATE_W-1:0] S_ADDIEXEC = 4'd9;
    localparam logic [STATE_W-1:0] S_ADDIWB   = 4'd10;
`ifdef MC_CONTROLLER_JUMP_EN
    localparam logic [STATE_W-1:0] S_JUMP     = 4'd11;
`endif

    typedef enum logic [STATE_W-1:0] {
        FETCH    = S_FETCH,
        DECODE   = S_DECODE,
        MEMADR   = S_MEMADR,
        MEMRD    = S_MEMRD,
        MEMWB    = S_MEMWB,
        MEMWR    = S_MEMWR,
        EXECUTE  = S_EXECUTE,
        ALUWB    = S_ALUWB,
        BRANCH   = S_BRANCH,
        ADDIEXEC = S_ADDIEXEC,
`ifdef MC_CONTROLLER_JUMP_EN
        ADDIWB   = S_ADDIWB,
        JUMP     = S_JUMP
`else
        ADDIWB   = S_ADDIWB
`endif
    } state_t;

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: turns the FSM's aluop request and the R-type funct field
// into the 3-bit ALU operation code. Purely combinational.
//   i_aluop       2  00 add, 01 sub, 10 decode funct
//   i_funct       6  R-type function field
//   o_alucontrol  3  ALU operation code
module mc_controller_aludec
    import mc_controller_pkg::*;
(
    input  logic [ALUOP_W-1:0] i_aluop,
    input  logic [FUNCT_W-1:0] i_funct,
    output logic [ALUC_W-1:0]  o_alucontrol
);

    always_comb begin
        o_alucontrol = ALU_NONE;
        case (i_aluop)
            ALUOP_ADD: o_alucontrol = ALU_ADD;
            ALUOP_SUB: o_alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FN_ADD:  o_alucontrol = ALU_ADD;
                    FN_SUB:  o_alucontrol = ALU_SUB;
                    FN_AND:  o_alucontrol = ALU_AND;
                    FN_OR:   o_alucontrol = ALU_OR;
                    FN_SLT:  o_alucontrol = ALU_SLT;
                    default: o_alucontrol = ALU_NONE;
                endcase
            end
            default: o_alucontrol = ALU_NONE;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-style control unit: Moore FSM sequencing fetch, decode and
// per-instruction execute/writeback steps, driving datapath enables/selects.
// Feature macro: MC_CONTROLLER_JUMP_EN adds the JUMP state for op 000010;
// without it that opcode decodes as a NOP.
// Ports:
//   clk, reset (async, active high)
//   op[5:0], funct[5:0], zero           instruction fields, ALU zero flag
//   pcen                                 pcwrite | (branch & zero), combinational
//   irwrite, memwrite, regwrite          write enables
//   iord, alusrca, regdst, memtoreg      mux selects
//   alusrcb[1:0], pcsrc[1:0]             ALU B / next-PC selects
//   alucontrol[2:0]                      ALU operation
module mc_controller
    import mc_controller_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               zero,
    output logic               pcen,
    output logic               irwrite,
    output logic               memwrite,
    output logic               regwrite,
    output logic               iord,
    output logic               alusrca,
    output logic               regdst,
    output logic               memtoreg,
    output logic [SEL_W-1:0]   alusrcb,
    output logic [SEL_W-1:0]   pcsrc,
    output logic [ALUC_W-1:0]  alucontrol
);

    state_t              r_state;
    state_t              w_next_state;
    logic                w_pcwrite;
    logic                w_branch;
    logic                w_alu_en;
    logic [ALUOP_W-1:0]  w_aluop;
    logic [ALUC_W-1:0]   w_alucontrol;

    // State register; reset abandons any partial instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= FETCH;
        else       r_state <= w_next_state;
    end

    // Next-state and Moore output decode; outputs held at 0 while in reset.
    always_comb begin
        w_next_state = FETCH;
        w_pcwrite    = 1'b0;
        w_branch     = 1'b0;
        w_alu_en     = 1'b0;
        w_aluop      = ALUOP_ADD;
        irwrite      = 1'b0;
        memwrite     = 1'b0;
        regwrite     = 1'b0;
        iord         = 1'b0;
        alusrca      = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        alusrcb      = SRCB_REG;
        pcsrc        = PCSRC_ALU;

        case (r_state)
            FETCH:    w_next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next_state = MEMADR;
                    OP_RTYPE:     w_next_state = EXECUTE;
                    OP_BEQ:       w_next_state = BRANCH;
                    OP_ADDI:      w_next_state = ADDIEXEC;
`ifdef MC_CONTROLLER_JUMP_EN
                    OP_J:         w_next_state = JUMP;
`endif
                    default:      w_next_state = FETCH;
                endcase
            end
            // Only lw/sw reach MEMADR, so anything but sw is a load.
            MEMADR:   w_next_state = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:    w_next_state = MEMWB;
            EXECUTE:  w_next_state = ALUWB;
            ADDIEXEC: w_next_state = ADDIWB;
            default:  w_next_state = FETCH;
        endcase

        if (!reset) begin
            case (r_state)
                FETCH: begin
                    irwrite   = 1'b1;
                    w_pcwrite = 1'b1;
                    alusrcb   = SRCB_FOUR;
                    w_alu_en  = 1'b1;
                end
                DECODE: begin
                    alusrcb  = SRCB_IMMSH;
                    w_alu_en = 1'b1;
                end
                MEMADR, ADDIEXEC: begin
                    alusrca  = 1'b1;
                    alusrcb  = SRCB_IMM;
                    w_alu_en = 1'b1;
                end
                MEMRD: iord = 1'b1;
                MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                end
                MEMWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                EXECUTE: begin
                    alusrca  = 1'b1;
                    w_aluop  = ALUOP_FUNCT;
                    w_alu_en = 1'b1;
                end
                ALUWB: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                end
                BRANCH: begin
                    alusrca  = 1'b1;
                    w_aluop  = ALUOP_SUB;
                    w_alu_en = 1'b1;
                    pcsrc    = PCSRC_ALUOUT;
                    w_branch = 1'b1;
                end
                ADDIWB: regwrite = 1'b1;
`ifdef MC_CONTROLLER_JUMP_EN
                JUMP: begin
                    pcsrc     = PCSRC_JUMP;
                    w_pcwrite = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    mc_controller_aludec aludec (
        .i_aluop      (w_aluop),
        .i_funct      (funct),
        .o_alucontrol (w_alucontrol)
    );

    // States that do not use the ALU present alucontrol = 0.
    assign alucontrol = w_alu_en ? w_alucontrol : ALUC_W'(0);
    assign pcen       = w_pcwrite | (w_branch & zero);

endmodule

// File: tb/tb_mc_controller.sv
// Directed scoreboard bench for mc_controller: the driver pushes the expected
// state/output word for each cycle, the monitor pops and compares mid-cycle.
`timescale 1ns/1ps
module tb_mc_controller;
    import mc_controller_pkg::*;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, irwrite, memwrite, regwrite;
    logic       iord, alusrca, regdst, memtoreg;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .iord       (iord),
        .alusrca    (alusrca),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol)
    );

    // Output word: {pcen,irwrite,memwrite,regwrite,iord,alusrca,regdst,memtoreg,alusrcb,pcsrc,alucontrol}
    localparam logic [14:0] E_ZERO   = 15'd0;
    localparam logic [14:0] E_FETCH  = {8'b1100_0000, 2'b01, 2'b00, 3'b010};
    localparam logic [14:0] E_DECODE = {8'b0000_0000, 2'b11, 2'b00, 3'b010};
    localparam logic [14:0] E_MEMADR = {8'b0000_0100, 2'b10, 2'b00, 3'b010};
    localparam logic [14:0] E_MEMRD  = {8'b0000_1000, 2'b00, 2'b00, 3'b000};
    localparam logic [14:0] E_MEMWB  = {8'b0001_0001, 2'b00, 2'b00, 3'b000};
    localparam logic [14:0] E_MEMWR  = {8'b0010_1000, 2'b00, 2'b00, 3'b000};
    localparam logic [14:0] E_ALUWB  = {8'b0001_0010, 2'b00, 2'b00, 3'b000};
    localparam logic [14:0] E_ADDIEX = {8'b0000_0100, 2'b10, 2'b00, 3'b010};
    localparam logic [14:0] E_ADDIWB = {8'b0001_0000, 2'b00, 2'b00, 3'b000};
`ifdef MC_CONTROLLER_JUMP_EN
    localparam logic [14:0] E_JUMP   = {8'b1000_0000, 2'b00, 2'b10, 3'b000};
`endif

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [14:0] ex;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    event ev_sample;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] e_exec(input logic [2:0] alu);
        return {8'b0000_0100, 2'b00, 2'b00, alu};
    endfunction

    function automatic logic [14:0] e_branch(input logic z);
        return {z, 7'b000_0100, 2'b00, 2'b01, 3'b110};
    endfunction

    // One clock cycle of stimulus plus the expectation for that cycle.
    task automatic step(input logic r, input logic [5:0] o, input logic [5:0] f,
                        input logic z, input string tag, input logic [3:0] st,
                        input logic [14:0] ex);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r;
        op    = o;
        funct = f;
        zero  = z;
        e.tag = tag;
        e.st  = st;
        e.ex  = ex;
        q.push_back(e);
    endtask

    task automatic run_rtype(input logic [5:0] f, input logic [2:0] alu, input string nm);
        step(1'b0, OP_RTYPE, f, 1'b0, {nm, "_fetch"},  S_FETCH,   E_FETCH);
        step(1'b0, OP_RTYPE, f, 1'b0, {nm, "_decode"}, S_DECODE,  E_DECODE);
        step(1'b0, OP_RTYPE, f, 1'b0, {nm, "_exec"},   S_EXECUTE, e_exec(alu));
        step(1'b0, OP_RTYPE, f, 1'b0, {nm, "_aluwb"},  S_ALUWB,   E_ALUWB);
    endtask

    task automatic run_beq(input logic z, input string nm);
        step(1'b0, OP_BEQ, 6'd0, z, {nm, "_fetch"},  S_FETCH,  E_FETCH);
        step(1'b0, OP_BEQ, 6'd0, z, {nm, "_decode"}, S_DECODE, E_DECODE);
        step(1'b0, OP_BEQ, 6'd0, z, {nm, "_branch"}, S_BRANCH, e_branch(z));
    endtask

    task automatic run_mem_head(input logic [5:0] o, input string nm);
        step(1'b0, o, 6'd0, 1'b0, {nm, "_fetch"},  S_FETCH,  E_FETCH);
        step(1'b0, o, 6'd0, 1'b0, {nm, "_decode"}, S_DECODE, E_DECODE);
        step(1'b0, o, 6'd0, 1'b0, {nm, "_memadr"}, S_MEMADR, E_MEMADR);
    endtask

    // Monitor: compares on every mid-cycle sample or on an explicit request.
    initial begin
        exp_t e;
        logic [14:0] act;
        forever begin
            @(negedge clk or ev_sample);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {pcen, irwrite, memwrite, regwrite, iord, alusrca, regdst,
                       memtoreg, alusrcb, pcsrc, alucontrol};
                n_tests++;
                if ({4'(dut.r_state), act} !== {e.st, e.ex}) begin
                    n_fail++;
                    $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                             e.tag, dut.r_state, act, e.st, e.ex);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        reset = 1'b1;
        op    = 6'd0;
        funct = 6'd0;
        zero  = 1'b0;

        // Reset held: all outputs 0; release lands in FETCH.
        step(1'b1, 6'd0, 6'd0, 1'b0, "rst_hold", S_FETCH, E_ZERO);
        run_rtype(FN_SUB, ALU_SUB,  "rsub");
        run_rtype(FN_ADD, ALU_ADD,  "radd");
        run_rtype(FN_AND, ALU_AND,  "rand");
        run_rtype(FN_OR,  ALU_OR,   "ror");
        run_rtype(FN_SLT, ALU_SLT,  "rslt");
        run_rtype(6'b000000, ALU_NONE, "rbad");

        run_beq(1'b1, "beq_taken");
        run_beq(1'b0, "beq_not");

        // lw: 5 cycles
        run_mem_head(OP_LW, "lw");
        step(1'b0, OP_LW, 6'd0, 1'b0, "lw_memrd", S_MEMRD, E_MEMRD);
        step(1'b0, OP_LW, 6'd0, 1'b0, "lw_memwb", S_MEMWB, E_MEMWB);

        // sw: 4 cycles, memwrite only in the fourth
        run_mem_head(OP_SW, "sw");
        step(1'b0, OP_SW, 6'd0, 1'b0, "sw_memwr", S_MEMWR, E_MEMWR);

        // addi: 4 cycles
        step(1'b0, OP_ADDI, 6'd0, 1'b0, "addi_fetch",  S_FETCH,    E_FETCH);
        step(1'b0, OP_ADDI, 6'd0, 1'b0, "addi_decode", S_DECODE,   E_DECODE);
        step(1'b0, OP_ADDI, 6'd0, 1'b0, "addi_exec",   S_ADDIEXEC, E_ADDIEX);
        step(1'b0, OP_ADDI, 6'd0, 1'b0, "addi_wb",     S_ADDIWB,   E_ADDIWB);

        // Illegal op: DECODE straight back to FETCH, no write enables
        step(1'b0, 6'b111111, 6'd0, 1'b0, "ill_fetch",  S_FETCH,  E_FETCH);
        step(1'b0, 6'b111111, 6'd0, 1'b0, "ill_decode", S_DECODE, E_DECODE);

        // j: JUMP when enabled, otherwise a NOP
        step(1'b0, 6'b000010, 6'd0, 1'b0, "j_fetch",  S_FETCH,  E_FETCH);
        step(1'b0, 6'b000010, 6'd0, 1'b0, "j_decode", S_DECODE, E_DECODE);
`ifdef MC_CONTROLLER_JUMP_EN
        step(1'b0, 6'b000010, 6'd0, 1'b0, "j_jump",   S_JUMP,   E_JUMP);
`endif

        // Async reset asserted between edges while in MEMRD
        run_mem_head(OP_LW, "lwr");
        step(1'b0, OP_LW, 6'd0, 1'b0, "lwr_memrd", S_MEMRD, E_MEMRD);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        e.tag = "async_rst";
        e.st  = S_FETCH;
        e.ex  = E_ZERO;
        q.push_back(e);
        -> ev_sample;
        step(1'b1, OP_LW, 6'd0, 1'b0, "async_rst_hold", S_FETCH, E_ZERO);

        // Recovery after reset, then a final fetch
        run_rtype(FN_ADD, ALU_ADD, "post_rst");
        step(1'b0, 6'd0, 6'd0, 1'b0, "final_fetch", S_FETCH, E_FETCH);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  6  instruction opcode field, instr[31:26], valid from DECODE onward.
REQ-005 funct  input  6  R-type function field, instr[5:0].
REQ-006 zero  input  1  ALU zero flag from the datapath.
REQ-007 pcen  output  1  PC register enable.
REQ-008 irwrite, memwrite, regwrite  output  1 each  instruction-register, memory and register-file write enables.
REQ-009 iord, alusrca, regdst, memtoreg  output  1 each  datapath mux selects.
REQ-010 alusrcb, pcsrc  output  2 each  ALU B select and next-PC select.
REQ-011 alucontrol  output  3  ALU operation code.

Function
REQ-012 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB and JUMP. Each state asserts only the outputs listed for it; all other 1-bit outputs are 0, and alusrcb, pcsrc and alucontrol are 0 unless listed.
REQ-013 FETCH SHALL assert irwrite=1 and pcwrite=1, with alusrcb=01 and ALU add; it always transitions to DECODE.
REQ-014 DECODE SHALL drive alusrcb=11 with ALU add, then branch on op:
- 100011 or 101011 -> MEMADR
- 000000 -> EXECUTE
- 000100 -> BRANCH
- 001000 -> ADDIEXEC
- 000010 -> JUMP
- any other op -> FETCH (treated as a NOP)
REQ-015 MEMADR SHALL drive alusrca=1, alusrcb=10 with ALU add. It goes to MEMRD for lw and to MEMWR for sw.
REQ-016 The load/store states SHALL behave as follows:
- MEMRD: iord=1, then -> MEMWB
- MEMWB: memtoreg=1, regwrite=1, then -> FETCH
- MEMWR: iord=1, memwrite=1, then -> FETCH
REQ-017 EXECUTE SHALL drive alusrca=1, alusrcb=00 with alucontrol taken from funct, then -> ALUWB. ALUWB SHALL assert regdst=1 and regwrite=1, then -> FETCH.
REQ-018 BRANCH SHALL drive alusrca=1, alusrcb=00, ALU sub, pcsrc=01 and branch=1, then -> FETCH.
REQ-019 ADDIEXEC SHALL drive alusrca=1, alusrcb=10 with ALU add, then -> ADDIWB. ADDIWB SHALL assert regwrite=1, then -> FETCH.
REQ-020 JUMP SHALL drive pcsrc=10 and pcwrite=1, then -> FETCH.
REQ-021 pcen SHALL equal pcwrite OR (branch AND zero), combinationally from the current-cycle zero.
REQ-022 ALU operation encodings SHALL be:
- add=010, sub=110, and=000, or=001, slt=111
- R-type funct mapping: 100000->add, 100010->sub, 100100->and, 100101->or, 101010->slt
- any other funct -> 011 (unused code, ALU result 0)
REQ-023 Instruction latencies in cycles SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal op 2.

Reset
REQ-024 Asserting reset SHALL force the state to FETCH immediately, independent of clk, including mid-instruction; the partial instruction is abandoned.
REQ-025 While reset is high, every output SHALL be 0.
REQ-026 The first rising clk edge after reset deassertion SHALL occur in FETCH with FETCH outputs active.

Configuration
REQ-027 Macro MC_CONTROLLER_JUMP_EN SHALL control support for the j instruction.
- Defined: the JUMP state exists and op 000010 is handled per REQ-014 and REQ-020.
- Undefined: the JUMP state is absent, op 000010 is illegal (DECODE -> FETCH), and pcsrc never equals 10.

Structure
REQ-028 A shared package SHALL hold:
- opcode and funct constants
- the alucontrol encoding constants
- the state enumerated type
- the alusrcb and pcsrc select constants
REQ-029 The funct/aluop-to-alucontrol decode SHALL be one combinational sub-module named aludec, instantiated once. The FSM supplies a 2-bit aluop (00 add, 01 sub, 10 funct).

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Reset pulse, release, op=000000, funct=100010 -> states FETCH, DECODE, EXECUTE, ALUWB, FETCH; alucontrol=110 in EXECUTE; regwrite=1 only in ALUWB.
- op=000100, zero=1 in BRANCH -> pcen=1, pcsrc=01 for that cycle. Repeat with zero=0 -> pcen=0.
- op=100011 -> five cycles; iord=1 in MEMRD; memtoreg=1 and regwrite=1 in MEMWB. op=101011 -> memwrite=1 in the fourth cycle only.
- op=111111 -> DECODE returns to FETCH; no write enable asserted. funct=000000 in EXECUTE -> alucontrol=011.
- reset asserted between clock edges while in MEMRD -> outputs 0 and state FETCH before the next clk edge.
- op=000010 with MEMRD... j -> JUMP: pcwrite=1, pcsrc=10 when MC_CONTROLLER_JUMP_EN is defined; treated as illegal (DECODE -> FETCH) when it is not.
